// File: rtl/rv32i_types_pkg.sv
// Shared RV32I datapath types used by the pipeline stages.
package rv32i_types_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } load_t;

endpackage

// File: rtl/stage3_types_pkg.sv
// Types private to the 3-stage pipeline: memory sequencer state and LR/SC reservation.
package stage3_types_pkg;

    typedef enum logic [1:0] {DSEQ_IDLE, DSEQ_ACCESS, DSEQ_DONE} dseq_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
    } resv_t;

endpackage

// File: rtl/stage3_load_extender.sv
// Selects the addressed byte/halfword from a bus word and sign- or zero-extends it.
module stage3_load_extender
    import rv32i_types_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  byte_off,
    input  load_t       load_type,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (byte_off)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase
        lane_h = byte_off[1] ? word[31:16] : word[15:0];
        case (load_type)
            LB:      result = {{24{lane_b[7]}}, lane_b};
            LBU:     result = {24'd0, lane_b};
            LH:      result = {{16{lane_h[15]}}, lane_h};
            LHU:     result = {16'd0, lane_h};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/stage3_dmem_sequencer.sv
// Memory-stage controller: issues one data-bus access per ex_mem instruction, stalls
// the pipeline while it is pending, and owns the LR/SC reservation.
module stage3_dmem_sequencer
    import rv32i_types_pkg::*;
    import stage3_types_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned RESV_LSB       = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ex_valid,
    input  logic        ex_dren,
    input  logic        ex_dwen,
    input  logic        ex_reserve,
    input  logic        ex_exclusive,
    input  load_t       ex_load_type,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_wdata,
    input  logic [3:0]  ex_byte_en,
    input  logic        flush,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic        dbus_ren,
    output logic        dbus_wen,
    output logic [3:0]  dbus_byte_en,
    input  logic        dbus_busy,
    input  logic [31:0] dbus_rdata,
    output logic        mem_stall,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    output logic        mal_addr,
    output logic        bus_fault
);

    function automatic logic is_misaligned(input logic dren, input load_t lt,
                                           input logic [3:0] be, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (dren) begin
            case (lt)
                LW:      bad = (off != 2'b00);
                LH, LHU: bad = off[0];
                default: bad = 1'b0;
            endcase
        end else if ($countones(be) == 4) begin
            bad = (off != 2'b00);
        end else if ($countones(be) == 2) begin
            bad = off[0];
        end
        return bad;
    endfunction

    dseq_state_t state, state_nxt;
    resv_t       resv;
    logic [31:0] timer;
    logic        flushed;
    load_t       ld_type_q;
    logic [1:0]  off_q;
    logic        lr_q, sc_q;
    logic [31:0] ext_data;
    logic [31:0] cur_addr;
    logic        request, misaligned, resv_match, sc_fail, timeout, squash, store_hits_resv;

    assign request    = ex_valid & (ex_dren | ex_dwen) & ~flush;
    assign misaligned = is_misaligned(ex_dren, ex_load_type, ex_byte_en, ex_addr[1:0]);
    assign resv_match = resv.valid && ((ex_addr >> RESV_LSB) == (resv.addr >> RESV_LSB));
    assign sc_fail    = ex_dwen & ex_exclusive & ~resv_match;
    assign timeout    = (TIMEOUT_CYCLES != 0) && dbus_busy && (timer == TIMEOUT_CYCLES - 1);
    assign squash     = flushed | flush;
    assign cur_addr   = {dbus_addr[31:2], off_q};
    assign store_hits_resv = dbus_wen && resv.valid &&
                             ((cur_addr >> RESV_LSB) == (resv.addr >> RESV_LSB));

    stage3_load_extender u_ext (
        .word      (dbus_rdata),
        .byte_off  (off_q),
        .load_type (ld_type_q),
        .result    (ext_data)
    );

    always_ff @(posedge CLK) begin
        if (RST) state <= DSEQ_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DSEQ_IDLE:
                if (request && !misaligned) state_nxt = sc_fail ? DSEQ_DONE : DSEQ_ACCESS;
            DSEQ_ACCESS:
                if (!dbus_busy)   state_nxt = DSEQ_DONE;
                else if (timeout) state_nxt = DSEQ_IDLE;
            default:
                state_nxt = DSEQ_IDLE;
        endcase
    end

    always_comb begin
        mem_stall = ((state == DSEQ_IDLE) && request) || (state == DSEQ_ACCESS);
        mem_done  = (state == DSEQ_DONE) && !squash;
    end

    // Access attributes needed only once the bus word returns.
    always_ff @(posedge CLK) begin
        if (state == DSEQ_IDLE && request) begin
            ld_type_q <= ex_load_type;
            off_q     <= ex_addr[1:0];
            lr_q      <= ex_dren & ex_reserve;
            sc_q      <= ex_dwen & ex_exclusive;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            dbus_addr    <= '0;
            dbus_wdata   <= '0;
            dbus_byte_en <= '0;
            dbus_ren     <= 1'b0;
            dbus_wen     <= 1'b0;
            mem_rdata    <= '0;
            mal_addr     <= 1'b0;
            bus_fault    <= 1'b0;
            timer        <= '0;
            flushed      <= 1'b0;
            resv         <= '0;
        end else begin
            mal_addr  <= 1'b0;
            bus_fault <= 1'b0;
            case (state)
                DSEQ_IDLE: begin
                    timer   <= '0;
                    flushed <= 1'b0;
                    if (request) begin
                        if (misaligned) begin
                            mal_addr <= 1'b1;
                        end else if (sc_fail) begin
                            mem_rdata  <= 32'd1;
                            resv.valid <= 1'b0;
                        end else begin
                            dbus_addr    <= {ex_addr[31:2], 2'b00};
                            dbus_wdata   <= ex_wdata;
                            dbus_byte_en <= ex_byte_en;
                            dbus_ren     <= ex_dren;
                            dbus_wen     <= ex_dwen & ~ex_dren;
                        end
                    end
                end
                DSEQ_ACCESS: begin
                    if (flush) flushed <= 1'b1;
                    if (!dbus_busy) begin
                        dbus_ren  <= 1'b0;
                        dbus_wen  <= 1'b0;
                        mem_rdata <= dbus_ren ? ext_data : 32'd0;
                        // A squashed access still completes on the bus but must not touch the reservation.
                        if (!squash) begin
                            if (lr_q)                 resv <= '{valid: 1'b1, addr: cur_addr};
                            else if (sc_q)            resv.valid <= 1'b0;
                            else if (store_hits_resv) resv.valid <= 1'b0;
                        end
                    end else if (timeout) begin
                        dbus_ren  <= 1'b0;
                        dbus_wen  <= 1'b0;
                        bus_fault <= 1'b1;
                        timer     <= '0;
                    end else if (TIMEOUT_CYCLES != 0) begin
                        timer <= timer + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_stage3_dmem_sequencer.sv
// Directed bench for the memory-stage sequencer with a queue scoreboard of retired results.
module tb_stage3_dmem_sequencer;
    import rv32i_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ex_valid, ex_dren, ex_dwen, ex_reserve, ex_exclusive, flush;
    load_t       ex_load_type;
    logic [31:0] ex_addr, ex_wdata;
    logic [3:0]  ex_byte_en;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata, mem_rdata;
    logic        dbus_ren, dbus_wen, dbus_busy;
    logic [3:0]  dbus_byte_en;
    logic        mem_stall, mem_done, mal_addr, bus_fault;

    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          wr_cnt = 0;
    int          wait_states = 0;
    int          wait_cnt = 0;
    logic        stuck_busy = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic [31:0] sb[$];

    stage3_dmem_sequencer #(.TIMEOUT_CYCLES(4), .RESV_LSB(2)) dut (
        .CLK(CLK), .RST(RST), .ex_valid(ex_valid), .ex_dren(ex_dren), .ex_dwen(ex_dwen),
        .ex_reserve(ex_reserve), .ex_exclusive(ex_exclusive), .ex_load_type(ex_load_type),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_byte_en(ex_byte_en), .flush(flush),
        .dbus_addr(dbus_addr), .dbus_wdata(dbus_wdata), .dbus_ren(dbus_ren), .dbus_wen(dbus_wen),
        .dbus_byte_en(dbus_byte_en), .dbus_busy(dbus_busy), .dbus_rdata(dbus_rdata),
        .mem_stall(mem_stall), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .mal_addr(mal_addr), .bus_fault(bus_fault)
    );

    always #5 CLK = ~CLK;

    // Bus slave: optional wait states, or busy held high indefinitely.
    assign dbus_busy  = stuck_busy | ((dbus_ren | dbus_wen) && (wait_cnt < wait_states));
    assign dbus_rdata = bus_rdata;

    always @(posedge CLK) begin
        if ((dbus_ren | dbus_wen) && dbus_busy) wait_cnt <= wait_cnt + 1;
        else                                   wait_cnt <= 0;
        if (dbus_wen && !dbus_busy) wr_cnt <= wr_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (mem_done) begin
            done_cnt++;
            chk("done_expected", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) chk("mem_rdata", mem_rdata, sb.pop_front());
        end
    end

    task automatic idle_inputs();
        ex_valid = 1'b0; ex_dren = 1'b0; ex_dwen = 1'b0; ex_reserve = 1'b0;
        ex_exclusive = 1'b0; ex_load_type = LW; ex_addr = '0; ex_wdata = '0;
        ex_byte_en = '0; flush = 1'b0;
    endtask

    task automatic drive(input logic dren, input logic dwen, input logic rsv, input logic excl,
                         input load_t lt, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be);
        ex_valid = 1'b1; ex_dren = dren; ex_dwen = dwen; ex_reserve = rsv; ex_exclusive = excl;
        ex_load_type = lt; ex_addr = addr; ex_wdata = wdata; ex_byte_en = be;
    endtask

    task automatic access(input string tag, input logic dren, input logic dwen, input logic rsv,
                          input logic excl, input load_t lt, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input logic [31:0] rdata,
                          input logic [31:0] exp, input int exp_cyc, input logic exp_ren,
                          input logic exp_wen);
        int   ncyc;
        logic saw_ren, saw_wen, got;
        ncyc = 0; saw_ren = 1'b0; saw_wen = 1'b0; got = 1'b0;
        bus_rdata = rdata;
        drive(dren, dwen, rsv, excl, lt, addr, wdata, be);
        sb.push_back(exp);
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge CLK); #1;
            ncyc++;
            saw_ren |= dbus_ren;
            saw_wen |= dbus_wen;
            if (mem_done) got = 1'b1;
        end
        idle_inputs();
        chk({tag, "_done"}, {31'd0, got}, 32'd1);
        chk({tag, "_latency"}, 32'(ncyc), 32'(exp_cyc));
        chk({tag, "_ren"}, {31'd0, saw_ren}, {31'd0, exp_ren});
        chk({tag, "_wen"}, {31'd0, saw_wen}, {31'd0, exp_wen});
        @(posedge CLK); #1;
    endtask

    initial begin : stim
        int   ncyc, ren_cyc, done0;
        logic got, saw_done;

        idle_inputs();
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_ren", {31'd0, dbus_ren}, 32'd0);
        chk("rst_wen", {31'd0, dbus_wen}, 32'd0);
        chk("rst_addr", dbus_addr, 32'd0);
        chk("rst_ctrl", {28'd0, mem_stall, mem_done, mal_addr, bus_fault}, 32'd0);
        chk("rst_rdata", mem_rdata, 32'd0);
        RST = 1'b0;
        @(posedge CLK); #1;

        // LW with zero wait states: strobe in cycle 2, done in cycle 3
        bus_rdata = 32'hDEADBEEF;
        drive(1'b1, 1'b0, 1'b0, 1'b0, LW, 32'h100, 32'h0, 4'hF);
        sb.push_back(32'hDEADBEEF);
        #1;
        chk("lw_c1_stall", {31'd0, mem_stall}, 32'd1);
        chk("lw_c1_ren", {31'd0, dbus_ren}, 32'd0);
        @(posedge CLK); #1;
        chk("lw_c2_ren", {31'd0, dbus_ren}, 32'd1);
        chk("lw_c2_addr", dbus_addr, 32'h100);
        chk("lw_c2_stall", {31'd0, mem_stall}, 32'd1);
        @(posedge CLK); #1;
        chk("lw_c3_done", {31'd0, mem_done}, 32'd1);
        chk("lw_c3_stall", {31'd0, mem_stall}, 32'd0);
        chk("lw_c3_ren", {31'd0, dbus_ren}, 32'd0);
        idle_inputs();
        @(posedge CLK); #1;
        chk("lw_c4_done", {31'd0, mem_done}, 32'd0);

        // Load extension
        access("lb",  1, 0, 0, 0, LB,  32'h103, 0, 4'h8, 32'h80FF_0000, 32'hFFFF_FF80, 2, 1, 0);
        access("lbu", 1, 0, 0, 0, LBU, 32'h103, 0, 4'h8, 32'h80FF_0000, 32'h0000_0080, 2, 1, 0);
        access("lbp", 1, 0, 0, 0, LB,  32'h101, 0, 4'h2, 32'h0000_7F00, 32'h0000_007F, 2, 1, 0);
        wait_states = 2;
        access("lh",  1, 0, 0, 0, LH,  32'h102, 0, 4'hC, 32'h8001_1234, 32'hFFFF_8001, 4, 1, 0);
        wait_states = 0;
        access("lhu", 1, 0, 0, 0, LHU, 32'h102, 0, 4'hC, 32'h8001_1234, 32'h0000_8001, 2, 1, 0);

        // LR/SC pairs
        access("lr1",  1, 0, 1, 0, LW, 32'h200, 0, 4'hF, 32'h1122_3344, 32'h1122_3344, 2, 1, 0);
        access("sc1",  0, 1, 0, 1, LW, 32'h200, 32'hA5A5_A5A5, 4'hF, 0, 32'd0, 2, 0, 1);
        access("sc2",  0, 1, 0, 1, LW, 32'h200, 32'hA5A5_A5A5, 4'hF, 0, 32'd1, 1, 0, 0);
        access("lr2",  1, 0, 1, 0, LW, 32'h200, 0, 4'hF, 32'h5555_0000, 32'h5555_0000, 2, 1, 0);
        wait_states = 1;
        access("sw",   0, 1, 0, 0, LW, 32'h200, 32'h0BAD_F00D, 4'hF, 0, 32'd0, 3, 0, 1);
        wait_states = 0;
        access("sc3",  0, 1, 0, 1, LW, 32'h200, 32'h1, 4'hF, 0, 32'd1, 1, 0, 0);
        chk("wr_count", 32'(wr_cnt), 32'd2);

        // Misaligned halfword load and word store
        drive(1'b1, 1'b0, 1'b0, 1'b0, LH, 32'h101, 32'h0, 4'h6);
        #1;
        chk("mal_lh_stall", {31'd0, mem_stall}, 32'd1);
        @(posedge CLK); #1;
        idle_inputs();
        #1;
        chk("mal_lh_pulse", {31'd0, mal_addr}, 32'd1);
        chk("mal_lh_stall2", {31'd0, mem_stall}, 32'd0);
        chk("mal_lh_ren", {31'd0, dbus_ren}, 32'd0);
        @(posedge CLK); #1;
        chk("mal_lh_clear", {31'd0, mal_addr}, 32'd0);
        chk("mal_lh_ren2", {31'd0, dbus_ren}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, LW, 32'h202, 32'h0, 4'hF);
        @(posedge CLK); #1;
        idle_inputs();
        chk("mal_sw_pulse", {31'd0, mal_addr}, 32'd1);
        chk("mal_sw_wen", {31'd0, dbus_wen}, 32'd0);
        @(posedge CLK); #1;

        // Watchdog: reservation must survive the fault
        access("lr5", 1, 0, 1, 0, LW, 32'h500, 0, 4'hF, 32'h0000_0500, 32'h0000_0500, 2, 1, 0);
        stuck_busy = 1'b1;
        done0 = done_cnt;
        drive(1'b1, 1'b0, 1'b0, 1'b0, LW, 32'h300, 32'h0, 4'hF);
        ncyc = 0; ren_cyc = 0; got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge CLK); #1;
            ncyc++;
            if (dbus_ren) ren_cyc++;
            if (bus_fault) got = 1'b1;
        end
        idle_inputs();
        #1;
        chk("wd_fault", {31'd0, got}, 32'd1);
        chk("wd_latency", 32'(ncyc), 32'd5);
        chk("wd_ren_cycles", 32'(ren_cyc), 32'd4);
        chk("wd_ren_low", {31'd0, dbus_ren}, 32'd0);
        chk("wd_stall_low", {31'd0, mem_stall}, 32'd0);
        @(posedge CLK); #1;
        chk("wd_fault_clear", {31'd0, bus_fault}, 32'd0);
        chk("wd_no_done", 32'(done_cnt), 32'(done0));
        stuck_busy = 1'b0;
        access("sc5", 0, 1, 0, 1, LW, 32'h500, 32'h7, 4'hF, 0, 32'd0, 2, 0, 1);

        // Flush during ACCESS: transfer completes silently, LR reservation not taken
        access("lr6", 1, 0, 1, 0, LW, 32'h600, 0, 4'hF, 32'h0000_0600, 32'h0000_0600, 2, 1, 0);
        stuck_busy = 1'b1;
        done0 = done_cnt;
        drive(1'b1, 1'b0, 1'b1, 1'b0, LW, 32'h400, 32'h0, 4'hF);
        @(posedge CLK); #1;
        chk("fl_ren", {31'd0, dbus_ren}, 32'd1);
        idle_inputs();
        flush = 1'b1;
        @(posedge CLK); #1;
        flush = 1'b0;
        @(posedge CLK); #1;
        stuck_busy = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            saw_done |= mem_done;
        end
        chk("fl_no_done_pin", {31'd0, saw_done}, 32'd0);
        chk("fl_no_done_cnt", 32'(done_cnt), 32'(done0));
        chk("fl_ren_low", {31'd0, dbus_ren}, 32'd0);
        access("sc4", 0, 1, 0, 1, LW, 32'h400, 32'h9, 4'hF, 0, 32'd1, 1, 0, 0);

        // Flush in DONE suppresses the done pulse
        done0 = done_cnt;
        drive(1'b1, 1'b0, 1'b0, 1'b0, LW, 32'h700, 32'h0, 4'hF);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        flush = 1'b1;
        #1;
        chk("fd_done", {31'd0, mem_done}, 32'd0);
        chk("fd_stall", {31'd0, mem_stall}, 32'd0);
        @(posedge CLK); #1;
        idle_inputs();
        @(posedge CLK); #1;
        chk("fd_no_done_cnt", 32'(done_cnt), 32'(done0));

        // Reset in the middle of an access withdraws the strobe
        stuck_busy = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, LW, 32'h800, 32'h0, 4'hF);
        @(posedge CLK); #1;
        chk("rma_ren", {31'd0, dbus_ren}, 32'd1);
        idle_inputs();
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("rma_ren_low", {31'd0, dbus_ren}, 32'd0);
        chk("rma_stall_low", {31'd0, mem_stall}, 32'd0);
        stuck_busy = 1'b0;
        @(posedge CLK); #1;

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
